// File: rtl/posit_defines_pkg.sv
// Shared posit pack-width helpers and arbiter state type.
// Packed operand/result layout: {sign, zero, NaR, scale, fraction}, sign in the MSB.
package posit_defines;

  function automatic int frac_w_normal(input int n, input int es);
    return n - es - 3;
  endfunction

  function automatic int scale_w_normal(input int n, input int es);
    return $clog2(n) + es + 1;
  endfunction

  // Product of two normalized mantissas keeps every bit below the leading one.
  function automatic int frac_w_amult(input int n, input int es);
    return 2 * frac_w_normal(n, es) + 1;
  endfunction

  function automatic int scale_w_amult(input int n, input int es);
    return scale_w_normal(n, es) + 1;
  endfunction

  function automatic int op_w(input int n, input int es);
    return 3 + scale_w_normal(n, es) + frac_w_normal(n, es);
  endfunction

  function automatic int res_w(input int n, input int es);
    return 3 + scale_w_amult(n, es) + frac_w_amult(n, es);
  endfunction

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

endpackage

// File: rtl/posit_tag_fifo.sv
// Synchronous FIFO holding the requester tag of every operation in flight
// through the shared multiplier.
module posit_tag_fifo #(
  parameter  int TAG_W = 2,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [TAG_W-1:0] din,
  output logic [TAG_W-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/posit_mult_arbiter.sv
// Window-granular round-robin sharing of one posit_mult between NUM_REQ lanes,
// with tag-based in-order routing of results back to the issuing lane.
module posit_mult_arbiter
  import posit_defines::*;
#(
  parameter  int POSIT_WIDTH  = 32,
  parameter  int POSIT_ES     = 2,
  parameter  int NUM_REQ      = 4,
  parameter  int MAX_INFLIGHT = 4,
  localparam int OPW          = op_w(POSIT_WIDTH, POSIT_ES),
  localparam int RESW         = res_w(POSIT_WIDTH, POSIT_ES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_rts_i,
  output logic [NUM_REQ-1:0]     req_rtr_o,
  input  logic [NUM_REQ-1:0]     req_sow_i,
  input  logic [NUM_REQ-1:0]     req_eow_i,
  input  logic [NUM_REQ*OPW-1:0] req_op1_i,
  input  logic [NUM_REQ*OPW-1:0] req_op2_i,
  output logic                   mult_rts_o,
  input  logic                   mult_rtr_i,
  output logic                   mult_sow_o,
  output logic                   mult_eow_o,
  output logic [OPW-1:0]         mult_op1_o,
  output logic [OPW-1:0]         mult_op2_o,
  input  logic                   mult_rts_i,
  output logic                   mult_rtr_o,
  input  logic [RESW-1:0]        mult_res_i,
  input  logic                   mult_sow_i,
  input  logic                   mult_eow_i,
  output logic [NUM_REQ-1:0]     res_rts_o,
  input  logic [NUM_REQ-1:0]     res_rtr_i,
  output logic [NUM_REQ-1:0]     res_sow_o,
  output logic [NUM_REQ-1:0]     res_eow_o,
  output logic [RESW-1:0]        res_o,
  output logic                   busy_o
);
  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  arb_state_t       state_q, state_d;
  logic [TAG_W-1:0] grant_q, grant_d, rr_q, rr_d, pick, head;
  logic [TAG_W:0]   scan_idx;
  logic             found, lock_rts, issue, pop, tag_full, tag_empty;
  logic [CNT_W-1:0] tag_count;
  logic [OPW-1:0]   op1_arr [NUM_REQ];
  logic [OPW-1:0]   op2_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op1_arr[i] = req_op1_i[i*OPW +: OPW];
      op2_arr[i] = req_op2_i[i*OPW +: OPW];
    end
  end

  // Round-robin scan: first requesting lane at or after the rr pointer.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, rr_q} + (TAG_W+1)'(i);
      if (scan_idx >= (TAG_W+1)'(NUM_REQ)) scan_idx = scan_idx - (TAG_W+1)'(NUM_REQ);
      if (!found && req_rts_i[scan_idx[TAG_W-1:0]]) begin
        found = 1'b1;
        pick  = scan_idx[TAG_W-1:0];
      end
    end
  end

  assign lock_rts = (state_q == ARB_LOCKED) & req_rts_i[grant_q] & ~tag_full;
  assign issue    = lock_rts & mult_rtr_i;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    req_rtr_o  = '0;
    mult_rts_o = 1'b0;
    mult_sow_o = 1'b0;
    mult_eow_o = 1'b0;
    mult_op1_o = '0;
    mult_op2_o = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (found) begin
          state_d = ARB_LOCKED;
          grant_d = pick;
        end
      end
      ARB_LOCKED: begin
        mult_rts_o         = lock_rts;
        req_rtr_o[grant_q] = mult_rtr_i & ~tag_full;
        mult_sow_o         = req_sow_i[grant_q];
        mult_eow_o         = req_eow_i[grant_q];
        mult_op1_o         = op1_arr[grant_q];
        mult_op2_o         = op2_arr[grant_q];
        // The release cycle never regrants, leaving one idle issue slot between windows.
        if (issue && req_eow_i[grant_q]) begin
          state_d = ARB_IDLE;
          rr_d    = (grant_q == TAG_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  posit_tag_fifo #(
    .TAG_W (TAG_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .pop   (pop),
    .din   (grant_q),
    .dout  (head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  // Results come back in issue order, so the FIFO head names the owner.
  always_comb begin
    res_rts_o = '0;
    res_sow_o = '0;
    res_eow_o = '0;
    if (!tag_empty) begin
      res_rts_o[head] = mult_rts_i;
      res_sow_o[head] = mult_sow_i;
      res_eow_o[head] = mult_eow_i;
    end
  end

  assign mult_rtr_o = res_rtr_i[head] & ~tag_empty;
  assign pop        = mult_rts_i & mult_rtr_o;
  assign res_o      = tag_empty ? '0 : mult_res_i;
  assign busy_o     = (state_q == ARB_LOCKED) | ~tag_empty;

  a_no_orphan_result: assert property (@(posedge clk) disable iff (rst)
    !(mult_rts_i && tag_empty));
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    tag_count <= CNT_W'(MAX_INFLIGHT));

endmodule

// File: tb/tb_posit_mult_arbiter.sv
// Randomized bench: requester queues, a behavioural posit multiplier with
// variable latency, and a scoreboard of per-lane expected products.
module tb_posit_mult_arbiter;
  import posit_defines::*;

  localparam int PW = 32, ES = 2, N = 4, MI = 4;
  localparam int OPW  = op_w(PW, ES);
  localparam int RESW = res_w(PW, ES);
  localparam int FN   = frac_w_normal(PW, ES);
  localparam int SN   = scale_w_normal(PW, ES);
  localparam int FA   = frac_w_amult(PW, ES);
  localparam int SA   = scale_w_amult(PW, ES);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b1;
  logic [N-1:0]         req_rts_i = '0, req_rtr_o, req_sow_i = '0, req_eow_i = '0;
  logic [N*OPW-1:0]     req_op1_i = '0, req_op2_i = '0;
  logic                 mult_rts_o, mult_rtr_i = 1'b0, mult_sow_o, mult_eow_o;
  logic [OPW-1:0]       mult_op1_o, mult_op2_o;
  logic                 mult_rts_i = 1'b0, mult_rtr_o, mult_sow_i = 1'b0, mult_eow_i = 1'b0;
  logic [RESW-1:0]      mult_res_i = '0, res_o;
  logic [N-1:0]         res_rts_o, res_rtr_i = '0, res_sow_o, res_eow_o;
  logic                 busy_o;

  posit_mult_arbiter #(
    .POSIT_WIDTH (PW),
    .POSIT_ES    (ES),
    .NUM_REQ     (N),
    .MAX_INFLIGHT(MI)
  ) dut (
    .clk(clk), .rst(rst),
    .req_rts_i(req_rts_i), .req_rtr_o(req_rtr_o), .req_sow_i(req_sow_i), .req_eow_i(req_eow_i),
    .req_op1_i(req_op1_i), .req_op2_i(req_op2_i),
    .mult_rts_o(mult_rts_o), .mult_rtr_i(mult_rtr_i), .mult_sow_o(mult_sow_o), .mult_eow_o(mult_eow_o),
    .mult_op1_o(mult_op1_o), .mult_op2_o(mult_op2_o),
    .mult_rts_i(mult_rts_i), .mult_rtr_o(mult_rtr_o), .mult_res_i(mult_res_i),
    .mult_sow_i(mult_sow_i), .mult_eow_i(mult_eow_i),
    .res_rts_o(res_rts_o), .res_rtr_i(res_rtr_i), .res_sow_o(res_sow_o), .res_eow_o(res_eow_o),
    .res_o(res_o), .busy_o(busy_o)
  );

  typedef struct packed {
    logic           sow;
    logic           eow;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } op_t;

  typedef struct {
    logic [RESW-1:0] r;
    logic            sow;
    logic            eow;
    int              ready;
  } mres_t;

  op_t             req_q [N][$];
  logic [RESW+1:0] exp_q [N][$];
  int              tag_q[$];
  mres_t           mq[$];
  int              issue_log[$], ret_log[$];
  logic [RESW-1:0] res_log[$];
  int              owner = -1, rr = 0, cyc = 0;
  int              errors = 0, checks = 0;
  int              gap_pct = 0, stall_pct = 0;
  logic            force_en = 1'b0, force_val = 1'b1;
  logic [N-1:0]    res_block = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Real-valued product of two normalized posits: sign xor, scales add, mantissas multiply.
  function automatic logic [RESW-1:0] pmul(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    logic sa, za, na, sb, zb, nb;
    logic signed [SN-1:0] ea, eb;
    logic [FN-1:0] fa, fb;
    logic [2*FN+1:0] m;
    logic signed [SA-1:0] e;
    logic [FA-1:0] f;
    {sa, za, na, ea, fa} = a;
    {sb, zb, nb, eb, fb} = b;
    if (na || nb) return {3'b001, {(SA+FA){1'b0}}};
    if (za || zb) return {3'b010, {(SA+FA){1'b0}}};
    m = (2*FN+2)'({1'b1, fa}) * (2*FN+2)'({1'b1, fb});
    e = SA'(ea) + SA'(eb);
    if (m[2*FN+1]) begin
      e = e + SA'(1);
      f = m[2*FN:0];
    end else begin
      f = {m[2*FN-1:0], 1'b0};
    end
    return {sa ^ sb, 2'b00, e, f};
  endfunction

  function automatic logic [OPW-1:0] mk_op(input logic s, input int sc, input logic [FN-1:0] f);
    return {s, 2'b00, SN'(sc), f};
  endfunction

  function automatic logic [OPW-1:0] rnd_op();
    if ($urandom_range(9) == 0) return {3'b010, {(SN+FN){1'b0}}};
    return mk_op(1'($urandom_range(1)), int'($urandom_range(40)) - 20, FN'($urandom));
  endfunction

  function automatic int first_set(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit model_idle();
    for (int c = 0; c < N; c++) if (req_q[c].size() != 0) return 1'b0;
    return (owner < 0) && (tag_q.size() == 0) && (mq.size() == 0);
  endfunction

  task automatic add_window(input int c, input int len);
    op_t op;
    for (int i = 0; i < len; i++) begin
      op.sow = (i == 0);
      op.eow = (i == len - 1);
      op.a   = rnd_op();
      op.b   = rnd_op();
      req_q[c].push_back(op);
    end
  endtask

  // One clock: check settled outputs at negedge, then advance models and drive after posedge.
  task automatic tick();
    logic [N-1:0] exp_rtr, exp_rres, rts_v, sow_v, eow_v;
    logic [N*OPW-1:0] op1_v, op2_v;
    logic exp_mrts, exp_mrtr, is_iss, is_ret, m_iss, m_ret, rst_s, s_sow, s_eow, found;
    logic [OPW-1:0] s_op1, s_op2;
    op_t op;
    mres_t mr;
    int h;
    @(negedge clk);
    exp_rtr = '0;
    exp_mrts = 1'b0;
    if (owner >= 0) begin
      exp_mrts = req_rts_i[owner] && (tag_q.size() < MI);
      exp_rtr[owner] = mult_rtr_i && (tag_q.size() < MI);
      if (exp_mrts) begin
        op = req_q[owner][0];
        chk("issue_ops", 128'({mult_sow_o, mult_eow_o, mult_op1_o, mult_op2_o}), 128'(op));
      end
    end
    chk("req_rtr", 128'(req_rtr_o), 128'(exp_rtr));
    chk("mult_rts", 128'(mult_rts_o), 128'(exp_mrts));
    exp_rres = '0;
    exp_mrtr = 1'b0;
    h = -1;
    if (tag_q.size() > 0) begin
      h = tag_q[0];
      exp_rres[h] = mult_rts_i;
      exp_mrtr = res_rtr_i[h];
    end
    chk("res_rts", 128'(res_rts_o), 128'(exp_rres));
    chk("mult_rtr", 128'(mult_rtr_o), 128'(exp_mrtr));
    if (h >= 0 && mult_rts_i && exp_mrtr)
      chk("res_data", 128'({res_sow_o[h], res_eow_o[h], res_o}), 128'(exp_q[h][0]));
    chk("busy", 128'(busy_o), 128'((owner >= 0) || (tag_q.size() > 0)));
    is_iss = mult_rts_o && mult_rtr_i;
    is_ret = mult_rts_i && mult_rtr_o;
    if (is_iss) issue_log.push_back(first_set(req_rts_i & req_rtr_o));
    if (is_ret) begin
      ret_log.push_back(first_set(res_rts_o & res_rtr_i));
      res_log.push_back(res_o);
    end
    s_op1 = mult_op1_o; s_op2 = mult_op2_o; s_sow = mult_sow_o; s_eow = mult_eow_o;
    m_iss = exp_mrts && mult_rtr_i;
    m_ret = (h >= 0) && mult_rts_i && exp_mrtr;
    rst_s = rst;

    @(posedge clk);
    #1;
    cyc++;
    if (rst_s) begin
      owner = -1;
      rr = 0;
      tag_q.delete();
      mq.delete();
      for (int c = 0; c < N; c++) begin
        req_q[c].delete();
        exp_q[c].delete();
      end
    end else begin
      if (m_ret) begin
        void'(tag_q.pop_front());
        void'(exp_q[h].pop_front());
      end
      if (owner < 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && req_rts_i[(rr + k) % N]) begin
            found = 1'b1;
            owner = (rr + k) % N;
          end
        end
      end else if (m_iss) begin
        op = req_q[owner].pop_front();
        tag_q.push_back(owner);
        exp_q[owner].push_back({op.sow, op.eow, pmul(op.a, op.b)});
        if (op.eow) begin
          rr = (owner + 1) % N;
          owner = -1;
        end
      end
      if (is_ret && mq.size() > 0) void'(mq.pop_front());
      if (is_iss) begin
        mr.r = pmul(s_op1, s_op2);
        mr.sow = s_sow;
        mr.eow = s_eow;
        mr.ready = cyc + int'($urandom_range(3, 1));
        mq.push_back(mr);
      end
    end
    rts_v = '0; sow_v = '0; eow_v = '0; op1_v = '0; op2_v = '0;
    for (int c = 0; c < N; c++) begin
      if (req_q[c].size() > 0) begin
        op = req_q[c][0];
        rts_v[c] = (int'($urandom_range(99)) >= gap_pct);
        sow_v[c] = op.sow;
        eow_v[c] = op.eow;
        op1_v[c*OPW +: OPW] = op.a;
        op2_v[c*OPW +: OPW] = op.b;
      end
    end
    req_rts_i = rts_v; req_sow_i = sow_v; req_eow_i = eow_v;
    req_op1_i = op1_v; req_op2_i = op2_v;
    mult_rtr_i = force_en ? force_val : (int'($urandom_range(99)) >= stall_pct);
    for (int c = 0; c < N; c++) res_rtr_i[c] = (int'($urandom_range(99)) >= stall_pct) && !res_block[c];
    if (mq.size() > 0) begin
      mult_rts_i = (mq[0].ready <= cyc);
      mult_res_i = mq[0].r;
      mult_sow_i = mq[0].sow;
      mult_eow_i = mq[0].eow;
    end else begin
      mult_rts_i = 1'b0;
      mult_res_i = '0;
      mult_sow_i = 1'b0;
      mult_eow_i = 1'b0;
    end
  endtask

  task automatic clear_logs();
    issue_log.delete();
    ret_log.delete();
    res_log.delete();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while (!model_idle() && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 128'(model_idle()), 128'(1));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctl"}, 128'({req_rtr_o, mult_rts_o, mult_sow_o, mult_eow_o, mult_rtr_o,
                             res_rts_o, res_sow_o, res_eow_o, busy_o}), 128'(0));
    chk({tag, "_ops"}, 128'({mult_op1_o, mult_op2_o}), 128'(0));
    chk({tag, "_res"}, 128'(res_o), 128'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t op;
    int n, cnt[N];
    logic [OPW-1:0] held;
    logic [RESW-1:0] exp15;

    // Single requester, 1.0 x 1.5
    do_reset(3);
    #1;
    chk_outputs_zero("reset");
    for (int i = 0; i < 3; i++) begin
      op.sow = (i == 0);
      op.eow = (i == 2);
      op.a = mk_op(1'b0, 0, '0);
      op.b = mk_op(1'b0, 0, {1'b1, {(FN-1){1'b0}}});
      req_q[0].push_back(op);
    end
    run_idle(200);
    #1;
    exp15 = {3'b000, {SA{1'b0}}, 1'b1, {(FA-1){1'b0}}};
    chk("s1_ret_count", 128'(ret_log.size()), 128'(3));
    for (int i = 0; i < ret_log.size(); i++) begin
      chk("s1_ret_lane", 128'(ret_log[i]), 128'(0));
      chk("s1_res_val", 128'(res_log[i]), 128'(exp15));
    end
    chk("s1_busy_drop", 128'(busy_o), 128'(0));

    // Contention between lanes 1 and 3
    do_reset(2);
    add_window(1, 2);
    add_window(3, 2);
    run_idle(300);
    chk("s2_issue_count", 128'(issue_log.size()), 128'(4));
    chk("s2_ret_count", 128'(ret_log.size()), 128'(4));
    for (int i = 0; i < 4 && i < issue_log.size() && i < ret_log.size(); i++) begin
      chk("s2_issue_order", 128'(issue_log[i]), 128'(i < 2 ? 1 : 3));
      chk("s2_ret_order", 128'(ret_log[i]), 128'(i < 2 ? 1 : 3));
    end

    // Round-robin fairness with continuous single-datum windows
    do_reset(2);
    for (int k = 0; k < 10; k++) for (int c = 0; c < N; c++) add_window(c, 1);
    run_idle(2000);
    for (int c = 0; c < N; c++) cnt[c] = 0;
    foreach (issue_log[i]) if (issue_log[i] >= 0) cnt[issue_log[i]]++;
    for (int c = 0; c < N; c++) chk("s3_share", 128'(cnt[c]), 128'(10));
    for (int i = 0; i < 5 && i < issue_log.size(); i++) chk("s3_rotation", 128'(issue_log[i]), 128'(i % N));

    // Result back-pressure on lane 2
    do_reset(2);
    res_block = 4'b0100;
    add_window(2, 6);
    repeat (30) tick();
    #1;
    chk("s4_inflight_cap", 128'(issue_log.size()), 128'(MI));
    chk("s4_rtr_blocked", 128'(req_rtr_o[2]), 128'(0));
    res_block = '0;
    run_idle(500);
    chk("s4_ret_count", 128'(ret_log.size()), 128'(6));
    foreach (ret_log[i]) chk("s4_ret_lane", 128'(ret_log[i]), 128'(2));

    // Reset while lane 1 holds the grant with two tags pending
    do_reset(2);
    res_block = '1;
    add_window(1, 4);
    n = 0;
    while (issue_log.size() < 2 && n < 60) begin
      tick();
      n++;
    end
    chk("s5_two_issued", 128'(issue_log.size()), 128'(2));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk_outputs_zero("s5_after_rst");
    clear_logs();
    res_block = '0;
    add_window(0, 2);
    run_idle(300);
    chk("s5_ret_count", 128'(ret_log.size()), 128'(2));
    foreach (ret_log[i]) chk("s5_ret_lane", 128'(ret_log[i]), 128'(0));

    // Downstream stall mid-window
    do_reset(2);
    force_en = 1'b1;
    force_val = 1'b1;
    add_window(0, 4);
    n = 0;
    while (issue_log.size() < 1 && n < 40) begin
      tick();
      n++;
    end
    force_val = 1'b0;
    mult_rtr_i = 1'b0;
    #1;
    held = mult_op1_o;
    repeat (5) tick();
    #1;
    chk("s6_no_issue", 128'(issue_log.size()), 128'(1));
    chk("s6_ops_held", 128'(mult_op1_o), 128'(held));
    chk("s6_grant_kept", 128'({mult_rts_o, busy_o}), 128'(2'b11));
    force_en = 1'b0;
    run_idle(300);

    // Random traffic with gaps and stalls on both sides
    do_reset(2);
    gap_pct = 20;
    stall_pct = 25;
    n = 0;
    for (int w = 0; w < 60; w++) begin
      int len = int'($urandom_range(4, 1));
      add_window(int'($urandom_range(N - 1)), len);
      n += len;
    end
    run_idle(6000);
    chk("s7_ret_count", 128'(ret_log.size()), 128'(n));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
